// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - sequences NUM_RND rounds of a block through a shared RND_LAT-stage AES round datapath.
// The datapath-facing and ciphertext outputs are themselves the key/state holding registers.
module aes_round_sequencer #(
  parameter int RND_LAT = 4,
  parameter int NUM_RND = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [127:0] key_in,
  input  logic [127:0] pt_in,
  output logic [3:0]   rnd_num,
  output logic [127:0] rnd_key_out,
  output logic [127:0] rnd_data_out,
  input  logic [127:0] rnd_key_in,
  input  logic [127:0] rnd_data_in,
  output logic         ct_valid,
  input  logic         ct_ready,
  output logic [127:0] ct_out,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAT_MAX  = 4'(RND_LAT);
  localparam logic [3:0] LAST_RND = 4'(NUM_RND);

  state_t     state;
  logic [3:0] cnt;

  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      rnd_num      <= 4'd0;
      rnd_key_out  <= 128'd0;
      rnd_data_out <= 128'd0;
      ct_valid     <= 1'b0;
      ct_out       <= 128'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            state        <= RUN;
            cnt          <= 4'd0;
            rnd_num      <= 4'd1;
            rnd_key_out  <= key_in;
            rnd_data_out <= pt_in ^ key_in;
          end
        end
        RUN: begin
          if (cnt == LAT_MAX) begin
            cnt <= 4'd0;
            if (rnd_num < LAST_RND) begin
              rnd_num      <= rnd_num + 4'd1;
              rnd_key_out  <= rnd_key_in;
              rnd_data_out <= rnd_data_in;
            end else begin
              // Round outputs drop to zero as the result moves to ct_out.
              state        <= DONE;
              rnd_num      <= 4'd0;
              rnd_key_out  <= 128'd0;
              rnd_data_out <= 128'd0;
              ct_valid     <= 1'b1;
              ct_out       <= rnd_data_in;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          if (ct_ready) begin
            state    <= IDLE;
            ct_valid <= 1'b0;
            ct_out   <= 128'd0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - self-checking bench with a behavioural AES round datapath and reference cipher.
module tb_aes_round_sequencer;

  localparam int LAT = 4;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid, start_ready, ct_valid, ct_ready, busy;
  logic [127:0] key_in, pt_in, rnd_key_out, rnd_data_out, rnd_key_in, rnd_data_in, ct_out;
  logic [3:0]   rnd_num;

  logic         sv2, sr2, cv2, cr2, busy2;
  logic [127:0] rko2, rdo2, rki2, rdi2, ct2;
  logic [3:0]   rn2;

  int checks = 0;
  int errors = 0;
  int age = 0;

  always #5 clk = ~clk;

  aes_round_sequencer dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .key_in(key_in), .pt_in(pt_in), .rnd_num(rnd_num), .rnd_key_out(rnd_key_out),
    .rnd_data_out(rnd_data_out), .rnd_key_in(rnd_key_in), .rnd_data_in(rnd_data_in),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_out(ct_out), .busy(busy)
  );

  aes_round_sequencer #(.RND_LAT(1), .NUM_RND(10)) dut2 (
    .clk(clk), .rst(rst), .start_valid(sv2), .start_ready(sr2),
    .key_in(key_in), .pt_in(pt_in), .rnd_num(rn2), .rnd_key_out(rko2),
    .rnd_data_out(rdo2), .rnd_key_in(rki2), .rnd_data_in(rdi2),
    .ct_valid(cv2), .ct_ready(cr2), .ct_out(ct2), .busy(busy2)
  );

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d = {x, x};
    return d[15-n -: 8];
  endfunction

  // S-box from first principles: GF(2^8) inverse (a^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] nextKey(input logic [127:0] k, input int rnd);
    logic [7:0]  rc = 8'h01;
    logic [31:0] t, w0, w1, w2, w3;
    for (int i = 1; i < rnd; i++) rc = xtime(rc);
    t  = {k[23:0], k[31:24]};
    t  = {sbox(t[31:24]) ^ rc, sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aesRound(input logic [127:0] s, input logic [127:0] k, input bit last);
    logic [7:0]   a [4][4];
    logic [7:0]   m [4][4];
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        a[r][c] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
    for (int c = 0; c < 4; c++) begin
      if (last) begin
        for (int r = 0; r < 4; r++) m[r][c] = a[r][c];
      end else begin
        m[0][c] = gmul(8'h02, a[0][c]) ^ gmul(8'h03, a[1][c]) ^ a[2][c] ^ a[3][c];
        m[1][c] = a[0][c] ^ gmul(8'h02, a[1][c]) ^ gmul(8'h03, a[2][c]) ^ a[3][c];
        m[2][c] = a[0][c] ^ a[1][c] ^ gmul(8'h02, a[2][c]) ^ gmul(8'h03, a[3][c]);
        m[3][c] = gmul(8'h03, a[0][c]) ^ a[1][c] ^ a[2][c] ^ gmul(8'h02, a[3][c]);
      end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(4*c+r) -: 8] = m[r][c];
    return o ^ k;
  endfunction

  function automatic logic [127:0] aesEncrypt(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] s = p ^ k;
    logic [127:0] rk = k;
    for (int r = 1; r <= 10; r++) begin
      rk = nextKey(rk, r);
      s  = aesRound(s, rk, r == 10);
    end
    return s;
  endfunction

  // Pipelined datapath stand-in: results are only correct once inputs have been held LAT cycles.
  always @(posedge clk) age <= (!busy || age == LAT) ? 0 : age + 1;

  always_comb begin
    logic [127:0] nk;
    nk          = nextKey(rnd_key_out, int'(rnd_num));
    rnd_key_in  = (age == LAT) ? nk : ~nk;
    rnd_data_in = (age == LAT) ? aesRound(rnd_data_out, nk, rnd_num == 4'd10)
                               : ~rnd_data_out;
  end

  always_comb begin
    logic [127:0] nk2;
    nk2  = nextKey(rko2, int'(rn2));
    rki2 = nk2;
    rdi2 = aesRound(rdo2, nk2, rn2 == 4'd10);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_start_ready"}, 128'(start_ready), 128'd1);
    check({tag, "_busy"}, 128'(busy), 128'd0);
    check({tag, "_ct_valid"}, 128'(ct_valid), 128'd0);
    check({tag, "_ct_out"}, ct_out, 128'd0);
    check({tag, "_rnd_num"}, 128'(rnd_num), 128'd0);
    check({tag, "_rnd_key_out"}, rnd_key_out, 128'd0);
    check({tag, "_rnd_data_out"}, rnd_data_out, 128'd0);
  endtask

  // Called just after a negedge; returns just after a negedge with the DUT idle again.
  task automatic runBlock(input string tag, input logic [127:0] k, input logic [127:0] p,
                          input logic [127:0] expCt, input int stall, input bit poke);
    int e = 0;
    int seqErr = 0;
    int stabErr = 0;
    logic [127:0] held;
    key_in = k; pt_in = p; start_valid = 1'b1;
    check({tag, "_ready_before_accept"}, 128'(start_ready), 128'd1);
    @(negedge clk);
    start_valid = poke;
    while (!ct_valid && e < 200) begin
      if (rnd_num !== 4'(e / (LAT + 1) + 1)) seqErr++;
      if (poke) begin
        key_in = {$urandom, $urandom, $urandom, $urandom};
        pt_in  = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      e++;
    end
    check({tag, "_latency"}, 128'(e), 128'd50);
    check({tag, "_round_sequence_errors"}, 128'(seqErr), 128'd0);
    check({tag, "_ct"}, ct_out, expCt);
    held = ct_out;
    repeat (stall) begin
      @(negedge clk);
      if (ct_valid !== 1'b1 || ct_out !== held || busy !== 1'b1) stabErr++;
    end
    if (stall > 0) check({tag, "_backpressure_stability_errors"}, 128'(stabErr), 128'd0);
    start_valid = 1'b0;
    ct_ready = 1'b1;
    @(negedge clk);
    ct_ready = 1'b0;
    check({tag, "_ct_valid_after_handshake"}, 128'(ct_valid), 128'd0);
    check({tag, "_ct_out_after_handshake"}, ct_out, 128'd0);
    check({tag, "_idle_after_handshake"}, 128'(start_ready), 128'd1);
  endtask

  initial begin
    int e, t1, t2, n;
    logic [127:0] c1, c2, rk, rp;

    rst = 1'b0; start_valid = 1'b0; ct_ready = 1'b0; sv2 = 1'b0; cr2 = 1'b0;
    key_in = '0; pt_in = '0;
    repeat (3) @(negedge clk);
    checkIdle("in_reset");
    rst = 1'b1;
    @(negedge clk);
    checkIdle("after_reset");

    runBlock("c1", C1_KEY, C1_PT, C1_CT, 0, 1'b0);
    runBlock("b_stall_poke", B_KEY, B_PT, B_CT, 20, 1'b1);

    // Reset during round 5, cnt 2.
    key_in = C1_KEY; pt_in = C1_PT; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (4 * (LAT + 1) + 2) @(negedge clk);
    check("mid_reset_round_before", 128'(rnd_num), 128'd5);
    rst = 1'b0;
    #1;
    checkIdle("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_reset_no_ct", 128'(ct_valid), 128'd0);
    runBlock("c1_after_reset", C1_KEY, C1_PT, C1_CT, 0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      runBlock($sformatf("rand%0d", i), rk, rp, aesEncrypt(rk, rp),
               int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end

    // Back-to-back with start_valid and ct_ready held high.
    key_in = B_KEY; pt_in = B_PT; start_valid = 1'b1; ct_ready = 1'b1;
    e = -1; n = 0; t1 = -1; t2 = -1; c1 = '0; c2 = '0;
    while (n < 2 && e < 300) begin
      @(negedge clk);
      e++;
      if (ct_valid) begin
        if (n == 0) begin
          t1 = e; c1 = ct_out; key_in = C1_KEY; pt_in = C1_PT;
        end else begin
          t2 = e; c2 = ct_out;
        end
        n++;
      end
    end
    start_valid = 1'b0;
    check("b2b_first_latency", 128'(t1), 128'd50);
    check("b2b_first_ct", c1, B_CT);
    check("b2b_second_time", 128'(t2), 128'd102);
    check("b2b_second_ct", c2, C1_CT);
    @(negedge clk);
    ct_ready = 1'b0;
    check("b2b_idle", 128'(start_ready), 128'd1);

    // RND_LAT=1 instance.
    key_in = B_KEY; pt_in = B_PT; sv2 = 1'b1;
    @(negedge clk);
    sv2 = 1'b0;
    e = 0;
    while (!cv2 && e < 200) begin
      @(negedge clk);
      e++;
    end
    check("lat1_latency", 128'(e), 128'd20);
    check("lat1_ct", ct2, B_CT);
    cr2 = 1'b1;
    @(negedge clk);
    cr2 = 1'b0;
    check("lat1_ct_valid_after_handshake", 128'(cv2), 128'd0);
    check("lat1_idle", 128'(sr2), 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 Parameter RND_LAT, default 4: register stages in the shared round datapath, legal range 1..15.
REQ-002 Parameter NUM_RND, default 10: rounds per block, legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start_valid  input  1  requester offers a block.
REQ-006 start_ready  output  1  sequencer accepts a block.
REQ-007 key_in  input  128  cipher key, bit 0 = MSB.
REQ-008 pt_in  input  128  plaintext, bit 0 = MSB.
REQ-009 rnd_num  output  4  current round number to datapath.
REQ-010 rnd_key_out  output  128  previous round key to datapath.
REQ-011 rnd_data_out  output  128  round state to datapath.
REQ-012 rnd_key_in  input  128  current round key from datapath.
REQ-013 rnd_data_in  input  128  round result from datapath.
REQ-014 ct_valid  output  1  ciphertext available.
REQ-015 ct_ready  input  1  consumer takes ciphertext.
REQ-016 ct_out  output  128  ciphertext.
REQ-017 busy  output  1  high in RUN or DONE.

Function
REQ-018 FSM states shall be IDLE, RUN and DONE.
REQ-019 start_ready shall be 1 exactly when in IDLE; start_valid outside IDLE is ignored and no request is queued.
REQ-020 Accept shall occur on an edge with start_valid=1 in IDLE: key_reg<=key_in, state_reg<=pt_in XOR key_in, rnd<=1, cnt<=0, go to RUN.
REQ-021 In RUN, rnd_num=rnd, rnd_key_out=key_reg and rnd_data_out=state_reg, all held stable for the whole round.
REQ-022 Each round shall last exactly RND_LAT+1 cycles; cnt increments every RUN cycle from 0 up to RND_LAT.
REQ-023 On the edge where cnt==RND_LAT: state_reg<=rnd_data_in, key_reg<=rnd_key_in, cnt<=0.
REQ-024 On that same edge, if rnd<NUM_RND then rnd<=rnd+1; otherwise go to DONE.
REQ-025 In DONE, ct_valid=1 and ct_out=state_reg, both held constant until the handshake completes.
REQ-026 On ct_valid AND ct_ready the FSM shall go to IDLE, with ct_valid low the next cycle; a new accept is possible from the following edge.
REQ-027 Latency from the accept edge to ct_valid rising shall be NUM_RND*(RND_LAT+1) edges; the default is 50.
REQ-028 Outside RUN, rnd_num, rnd_key_out and rnd_data_out shall be 0.
REQ-029 Outside DONE, ct_valid=0 and ct_out=0.
REQ-030 Final-round differences (no MixColumns) are handled by the datapath through rnd_num; the sequencer treats every round the same.
REQ-031 Datapath outputs shall be sampled only at the REQ-023 edge; values on other cycles are don't-care.
REQ-032 There are no combinational paths from any input to any output except start_ready and busy, which are decoded from state only.

Reset
REQ-033 While rst=0, the FSM shall be IDLE and all registers zero, asynchronously.
REQ-034 Outputs during reset shall be: start_ready=1 (IDLE), busy=0, ct_valid=0, ct_out=0, rnd_num=0, rnd_key_out=0, rnd_data_out=0.
REQ-035 Reset asserted mid-RUN or in DONE shall discard the block without emitting ct_valid; the first edge after release behaves as IDLE.

Verification
REQ-036 Reset: hold rst=0 for 3 cycles, release -> start_ready=1, busy=0, ct_valid=0, all data outputs 0.
REQ-037 FIPS-197 C.1 with the real round datapath: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a, ct_valid rising 50 edges after accept; rnd_num steps 1..10, each value held 5 cycles.
REQ-038 FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32.
REQ-039 Backpressure and ignored request: hold ct_ready=0 for 20 cycles in DONE -> ct_valid and ct_out stable throughout; start_valid=1 during RUN and DONE -> no accept and no effect on the result.
REQ-040 Reset mid-operation: assert rst during round 5, cnt=2 -> immediately IDLE with outputs zero; then encrypt the C.1 vector -> correct ct, latency 50.
REQ-041 Back-to-back: start_valid held high and ct_ready held high -> two blocks complete, the second accepted the edge after the first handshake; parameter sweep RND_LAT=1 gives latency 20.
